// File: rtl/uart_rx.sv
// 8N1 UART receiver: idle-high line, LSB first, mid-bit sampling, stop-bit framing check.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of samples at cnt==2,1,0.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = 13;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic             rx_m, rx_s, rx_s_d;
  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             valid_n, ferr_n, busy_n;
  logic             sample;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj_2, maj_1;

  // Capture the two earlier votes; the third is rx_s itself at cnt==0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_2 <= 1'b1;
      maj_1 <= 1'b1;
    end else begin
      if (cnt == CNT_W'(2)) maj_2 <= rx_s;
      if (cnt == CNT_W'(1)) maj_1 <= rx_s;
    end
  end

  assign sample = (maj_2 & maj_1) | (maj_2 & rx_s) | (maj_1 & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      rx_busy   <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    busy_n  = rx_busy;
    case (state)
      IDLE: begin
        // Only a genuine high-to-low transition starts a frame
        if (rx_s_d && !rx_s) begin
          state_n = START;
          cnt_n   = CNT_W'(HALF_BIT - 1);
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (sample) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            state_n = DATA;
            cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
            idx_n   = 3'd0;
          end
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_n[idx] = sample;
          idx_n        = idx + 3'd1;
          cnt_n        = CNT_W'(CLKS_PER_BIT - 1);
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (sample) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line recovers so a break reports a single error
        if (rx_s) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
